muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage. It accepts one operation via a start pulse, iterates one bit per cycle on operand magnitudes, applies sign correction, and returns a 32-bit result with a one-cycle done pulse. The execute-stage controller stalls the pipeline while `busy` is high.

---
 rtl/muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Multi-cycle RV32M multiply/divide unit for the execute stage. One operation
// is accepted per start pulse in IDLE. The unit iterates one bit per cycle on
// operand magnitudes, applies sign correction in FIX, and presents the result
// on C together with a one-cycle done pulse in DONE.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request, sampled only in IDLE
//   kill       pipeline flush; aborts any operation in flight (beats start)
//   funct3     RV32M op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   A, B       rs1 / rs2 operands
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse, C valid in the same cycle
//   C          result, held until the next completed operation
//   dbg_state  current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
//
// Handshake: start is a request that is honoured only in a cycle where
// busy=0 and kill=0; there is no queuing and a start while busy is dropped.
// done is the single-cycle completion strobe; there is no back-pressure.

module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             kill,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] C,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [5:0]       LAST_ITER = 6'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state;
   logic [5:0]         cnt;
   logic [2:0]         op;
   logic               sa_r;     // sign of A (remainder sign)
   logic               neg_r;    // signs differ: negate product / quotient
   logic               fast_r;   // result already final, skip sign fix
   logic [2*WIDTH-1:0] p;        // mul: {acc, multiplier}; div: {rem, quot}
   logic [WIDTH-1:0]   opnd;     // mul: multiplicand mag; div: divisor mag

   // Operand decode at the start request
   logic               is_div_in;
   logic               signed_a_in;
   logic               signed_b_in;
   logic               sa_in;
   logic               sb_in;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               div_zero;
   logic               div_ovf;
   logic [WIDTH-1:0]   fast_val;

   // Iteration step
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;

   // Final result
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   mul_out;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   fix_out;

   always_comb begin
      is_div_in   = funct3[2];
      // Unsigned A only for MULHU, DIVU, REMU (all have funct3[0]=1, funct3[1]=1 or [2]=1)
      signed_a_in = !((funct3 == 3'b011) || (funct3 == 3'b101) || (funct3 == 3'b111));
      signed_b_in = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
      sa_in       = signed_a_in & A[WIDTH-1];
      sb_in       = signed_b_in & B[WIDTH-1];
      a_mag       = sa_in ? -A : A;
      b_mag       = sb_in ? -B : B;

      div_zero    = is_div_in && (B == '0);
      div_ovf     = is_div_in && !funct3[0] && (A == MIN_NEG) && (B == '1);
      fast_val    = '0;
      if (div_zero) begin
         fast_val = funct3[1] ? A : '1;
      end else if (div_ovf) begin
         fast_val = funct3[1] ? '0 : MIN_NEG;
      end
   end

   always_comb begin
      // Shift-add: add multiplicand to the upper half when the current
      // multiplier bit is set, then shift the whole register right.
      mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : '0);
      mul_next = {mul_sum, p[WIDTH-1:1]};

      // Restoring division: bring the next dividend bit into the partial
      // remainder and subtract the divisor only if it fits.
      div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
      div_diff  = div_shift[WIDTH-1:0] - opnd;
      if (div_shift >= {1'b0, opnd}) begin
         div_next = {div_diff, p[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {div_shift[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      mul_res = neg_r ? -p : p;
      mul_out = (op == 3'b000) ? mul_res[WIDTH-1:0] : mul_res[2*WIDTH-1:WIDTH];
      quo     = neg_r ? -p[WIDTH-1:0] : p[WIDTH-1:0];
      rem     = sa_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
      if (fast_r) begin
         fix_out = p[WIDTH-1:0];
      end else if (op[2]) begin
         fix_out = op[1] ? rem : quo;
      end else begin
         fix_out = mul_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         done   <= 1'b0;
         C      <= '0;
         cnt    <= '0;
         op     <= '0;
         sa_r   <= 1'b0;
         neg_r  <= 1'b0;
         fast_r <= 1'b0;
         p      <= '0;
         opnd   <= '0;
      end else if (kill) begin
         // Abort: no done, C untouched
         state <= IDLE;
         done  <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op    <= funct3;
                  cnt   <= '0;
                  sa_r  <= sa_in;
                  neg_r <= sa_in ^ sb_in;
                  if (div_zero || div_ovf) begin
                     fast_r <= 1'b1;
                     p      <= {{WIDTH{1'b0}}, fast_val};
                     opnd   <= '0;
                     state  <= FIX;
                  end else begin
                     fast_r <= 1'b0;
                     p      <= {{WIDTH{1'b0}}, (is_div_in ? a_mag : b_mag)};
                     opnd   <= is_div_in ? b_mag : a_mag;
                     state  <= CALC;
                  end
               end
            end
            CALC: begin
               p   <= op[2] ? div_next : mul_next;
               cnt <= cnt + 6'd1;
               if (cnt == LAST_ITER) begin
                  state <= FIX;
               end
            end
            FIX: begin
               C     <= fix_out;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed bench for muldiv_unit: reset values, every RV32M op class, the
// divide-by-zero and signed-overflow fast paths, kill, ignored starts while
// busy, back-to-back issue and a mid-operation reset. Inputs are driven and
// outputs sampled on the falling edge; "cycle n" counts from the cycle in
// which start is presented.

module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        kill;
   logic [2:0]  funct3;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] C;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   logic [31:0] last_c;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .kill      (kill),
      .funct3    (funct3),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .C         (C),
      .dbg_state (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op in the current cycle, wait for done, check latency and C,
   // then step into the following cycle and check the unit is idle again.
   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_c, input int exp_lat);
      int n;
      start  = 1'b1;
      funct3 = f;
      A      = a;
      B      = b;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_c"}, C, exp_c);
      chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd1);
      last_c = exp_c;
      @(negedge clk);
      chk({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      logic done_seen;

      rst    = 1'b1;
      start  = 1'b0;
      kill   = 1'b0;
      funct3 = 3'b000;
      A      = '0;
      B      = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_c", C, 32'd0);
      chk("reset_state", {30'b0, dbg_state}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", {31'b0, busy}, 32'd0);

      // multiply
      do_op("mul_neg", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      do_op("mulhu_max", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      do_op("mulh_min", F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);

      // divide
      do_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      do_op("rem_neg", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      do_op("divu", F_DIVU, 32'd100, 32'd7, 32'd14, 34);
      do_op("remu", F_REMU, 32'd100, 32'd7, 32'd2, 34);

      // fast paths
      do_op("divu_zero", F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
      do_op("rem_zero", F_REM, 32'd5, 32'd0, 32'd5, 2);
      do_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      do_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

      // kill in cycle 10 of MUL 3x4
      start  = 1'b1;
      funct3 = F_MUL;
      A      = 32'd3;
      B      = 32'd4;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      done_seen = 1'b0;
      while (n < 10) begin
         done_seen = done_seen | done;
         @(negedge clk);
         n++;
      end
      chk("kill_busy_before", {31'b0, busy}, 32'd1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      done_seen = done_seen | done;
      chk("kill_busy_after", {31'b0, busy}, 32'd0);
      chk("kill_no_done", {31'b0, done_seen}, 32'd0);
      chk("kill_c_kept", C, last_c);
      do_op("after_kill", F_MUL, 32'd3, 32'd4, 32'd12, 34);

      // starts while busy are ignored
      start  = 1'b1;
      funct3 = F_DIVU;
      A      = 32'd100;
      B      = 32'd7;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 100) begin
         if (n == 5 || n == 20) begin
            start  = 1'b1;
            funct3 = F_MUL;
            A      = 32'd9;
            B      = 32'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk("ignore_lat", 32'(n), 32'd34);
      chk("ignore_c", C, 32'd14);
      @(negedge clk);
      chk("ignore_idle", {31'b0, busy}, 32'd0);
      do_op("back_to_back", F_REMU, 32'd100, 32'd7, 32'd2, 34);

      // reset in cycle 17 of a MUL
      start  = 1'b1;
      funct3 = F_MUL;
      A      = 32'd7;
      B      = 32'd5;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (n < 17) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_c", C, 32'd0);
      chk("rst_state", {30'b0, dbg_state}, 32'd0);
      done_seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         done_seen = done_seen | done;
      end
      chk("rst_no_done", {31'b0, done_seen}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
